control_unit: RTL and testbench

// - Main decoder of the single-cycle MIPS-subset CPU: maps opcode/funct (+ ALU zero flag) to datapath controls.
// - Sits between instruction memory and datapath: sign-extend unit, ALU B-mux, register file, data memory, next-PC mux.
// - Decode is combinational.
// - The clock/reset pair gates outputs to a safe NOP during reset and for the first clock edge after reset release.

---
 rtl/cpu_pkg.sv | 90 +++++++++
 rtl/control_unit.sv | 124 ++++++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS-subset CPU: opcodes, functs, ALU ops, mux selects
// and the control bundle driven by the main decoder.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_NOR = 4'b0101,
        ALU_SLT = 4'b0110,
        ALU_SLL = 4'b0111,
        ALU_SRL = 4'b1000,
        ALU_SRA = 4'b1001,
        ALU_LUI = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        DW_ALU  = 2'b00,
        DW_MEM  = 2'b01,
        DW_PC4  = 2'b10,
        DW_RSVD = 2'b11
    } dw_sel_e;

    typedef enum logic [1:0] {
        RW_RT   = 2'b00,
        RW_RD   = 2'b01,
        RW_RA   = 2'b10,
        RW_RSVD = 2'b11
    } rw_sel_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_RS     = 2'b11
    } npc_sel_e;

    typedef struct packed {
        logic     seu_en;
        logic     alu_src_b;
        alu_op_e  alu_op;
        dw_sel_e  dw_sel;
        rw_sel_e  rw_sel;
        logic     rf_wr_en;
        logic     dm_wr;
        logic     dm_rd;
        npc_sel_e next_pc_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        seu_en:      1'b0,
        alu_src_b:   1'b0,
        alu_op:      ALU_ADD,
        dw_sel:      DW_ALU,
        rw_sel:      RW_RT,
        rf_wr_en:    1'b0,
        dm_wr:       1'b0,
        dm_rd:       1'b0,
        next_pc_sel: NPC_SEQ
    };

endpackage

// File: rtl/control_unit.sv
// Main decoder: combinational opcode/funct/zero decode, held at the NOP vector
// until the first clock edge after reset release.
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       seu_en,
    output logic       alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] dw_sel,
    output logic [1:0] rw_sel,
    output logic       rf_wr_en,
    output logic       dm_wr,
    output logic       dm_rd,
    output logic [1:0] next_pc_sel
);

    logic  run_q;
    logic  run_d;
    ctrl_t ctrl_s;

    assign run_d = 1'b1;

    // Run flag: cleared asynchronously, set by the first edge out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_d;
        end
    end

    // Instruction decode; anything unrecognised falls back to the NOP vector
    always_comb begin
        ctrl_s = CTRL_NOP;
        if (run_q) begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl_s.rw_sel   = RW_RD;
                    ctrl_s.rf_wr_en = 1'b1;
                    case (funct)
                        FN_ADD:  ctrl_s.alu_op = ALU_ADD;
                        FN_SUB:  ctrl_s.alu_op = ALU_SUB;
                        FN_AND:  ctrl_s.alu_op = ALU_AND;
                        FN_OR:   ctrl_s.alu_op = ALU_OR;
                        FN_XOR:  ctrl_s.alu_op = ALU_XOR;
                        FN_NOR:  ctrl_s.alu_op = ALU_NOR;
                        FN_SLT:  ctrl_s.alu_op = ALU_SLT;
                        FN_SLL:  ctrl_s.alu_op = ALU_SLL;
                        FN_SRL:  ctrl_s.alu_op = ALU_SRL;
                        FN_SRA:  ctrl_s.alu_op = ALU_SRA;
                        FN_JR: begin
                            ctrl_s.rf_wr_en    = 1'b0;
                            ctrl_s.next_pc_sel = NPC_RS;
                        end
                        default: ctrl_s = CTRL_NOP;
                    endcase
                end
                OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    ctrl_s.alu_src_b = 1'b1;
                    ctrl_s.rf_wr_en  = 1'b1;
                    ctrl_s.seu_en    = (opcode == OP_ADDI) || (opcode == OP_SLTI);
                    case (opcode)
                        OP_SLTI: ctrl_s.alu_op = ALU_SLT;
                        OP_ANDI: ctrl_s.alu_op = ALU_AND;
                        OP_ORI:  ctrl_s.alu_op = ALU_OR;
                        OP_XORI: ctrl_s.alu_op = ALU_XOR;
                        OP_LUI:  ctrl_s.alu_op = ALU_LUI;
                        default: ctrl_s.alu_op = ALU_ADD;
                    endcase
                end
                OP_LW: begin
                    ctrl_s.seu_en    = 1'b1;
                    ctrl_s.alu_src_b = 1'b1;
                    ctrl_s.dm_rd     = 1'b1;
                    ctrl_s.dw_sel    = DW_MEM;
                    ctrl_s.rf_wr_en  = 1'b1;
                end
                OP_SW: begin
                    ctrl_s.seu_en    = 1'b1;
                    ctrl_s.alu_src_b = 1'b1;
                    ctrl_s.dm_wr     = 1'b1;
                end
                // Branch resolution is the only place zero reaches the outputs
                OP_BEQ, OP_BNE: begin
                    ctrl_s.seu_en = 1'b1;
                    ctrl_s.alu_op = ALU_SUB;
                    if ((opcode == OP_BEQ) ? zero : !zero) begin
                        ctrl_s.next_pc_sel = NPC_BRANCH;
                    end else begin
                        ctrl_s.next_pc_sel = NPC_SEQ;
                    end
                end
                OP_J: begin
                    ctrl_s.next_pc_sel = NPC_JUMP;
                end
                OP_JAL: begin
                    ctrl_s.next_pc_sel = NPC_JUMP;
                    ctrl_s.rf_wr_en    = 1'b1;
                    ctrl_s.rw_sel      = RW_RA;
                    ctrl_s.dw_sel      = DW_PC4;
                end
                default: ctrl_s = CTRL_NOP;
            endcase
        end else begin
            ctrl_s = CTRL_NOP;
        end
    end

    assign seu_en      = ctrl_s.seu_en;
    assign alu_src_b   = ctrl_s.alu_src_b;
    assign alu_op      = ctrl_s.alu_op;
    assign dw_sel      = ctrl_s.dw_sel;
    assign rw_sel      = ctrl_s.rw_sel;
    assign rf_wr_en    = ctrl_s.rf_wr_en;
    assign dm_wr       = ctrl_s.dm_wr;
    assign dm_rd       = ctrl_s.dm_rd;
    assign next_pc_sel = ctrl_s.next_pc_sel;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes model expectations, a
// negedge monitor pops and compares the decoded control vector.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       seu_en, alu_src_b, rf_wr_en, dm_wr, dm_rd;
    logic [3:0] alu_op;
    logic [1:0] dw_sel, rw_sel, next_pc_sel;

    int checks   = 0;
    int failures = 0;
    logic run_m;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } sb_item_t;
    sb_item_t sb_q[$];

    logic [3:0] r_alu[logic [5:0]];
    logic [3:0] i_alu[logic [5:0]];
    logic [5:0] op_list[13];
    logic [5:0] fn_list[11];

    localparam logic [14:0] NOP_V = 15'b0_0_0000_00_00_0_0_0_00;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .seu_en(seu_en), .alu_src_b(alu_src_b), .alu_op(alu_op), .dw_sel(dw_sel),
        .rw_sel(rw_sel), .rf_wr_en(rf_wr_en), .dm_wr(dm_wr), .dm_rd(dm_rd),
        .next_pc_sel(next_pc_sel)
    );

    always #5 clk = ~clk;

    // Reference notion of "running": true once a clock edge has seen rst_n high
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_m <= 1'b0;
        else        run_m <= 1'b1;
    end

    function automatic logic [14:0] actual_v();
        return {seu_en, alu_src_b, alu_op, dw_sel, rw_sel, rf_wr_en, dm_wr, dm_rd, next_pc_sel};
    endfunction

    // Behavioural model: classify instruction, then derive each control from rules
    function automatic logic [14:0] model(logic run, logic [5:0] op, logic [5:0] fn, logic z);
        bit r_alu_i, jr, i_alu_i, lw, sw, beq, bne, j, jal;
        logic [3:0] alu;
        logic [1:0] dw, rw, npc;
        bit seu, srcb, wr;
        r_alu_i = (op == 6'd0) && r_alu.exists(fn);
        jr      = (op == 6'd0) && (fn == 6'b001000);
        i_alu_i = i_alu.exists(op);
        lw  = (op == 6'b100011);
        sw  = (op == 6'b101011);
        beq = (op == 6'b000100);
        bne = (op == 6'b000101);
        j   = (op == 6'b000010);
        jal = (op == 6'b000011);
        if (!run || !(r_alu_i || jr || i_alu_i || lw || sw || beq || bne || j || jal))
            return NOP_V;
        alu  = r_alu_i ? r_alu[fn] : i_alu_i ? i_alu[op] : (beq || bne) ? 4'd1 : 4'd0;
        seu  = (op == 6'b001000) || (op == 6'b001010) || lw || sw || beq || bne;
        srcb = i_alu_i || lw || sw;
        dw   = lw ? 2'd1 : jal ? 2'd2 : 2'd0;
        rw   = (r_alu_i || jr) ? 2'd1 : jal ? 2'd2 : 2'd0;
        wr   = r_alu_i || i_alu_i || lw || jal;
        npc  = jr ? 2'd3 : (j || jal) ? 2'd2 : ((beq && z) || (bne && !z)) ? 2'd1 : 2'd0;
        return {seu, srcb, alu, dw, rw, wr, sw, lw, npc};
    endfunction

    task automatic compare(string name, logic [14:0] act, logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (op=%b fn=%b zero=%b)",
                     name, act, exp, opcode, funct, zero);
        end
    endtask

    task automatic apply(string name, logic [5:0] op, logic [5:0] fn, logic z);
        sb_item_t it;
        opcode = op;
        funct  = fn;
        zero   = z;
        it.name = name;
        it.exp  = model(run_m, op, fn, z);
        sb_q.push_back(it);
    endtask

    task automatic next_slot();
        @(posedge clk);
        #2;
    endtask

    // Monitor: combinational outputs are stable by the falling edge
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            compare(it.name, actual_v(), it.exp);
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        r_alu[6'b100000] = 4'd0;  r_alu[6'b100010] = 4'd1;  r_alu[6'b100100] = 4'd2;
        r_alu[6'b100101] = 4'd3;  r_alu[6'b100110] = 4'd4;  r_alu[6'b100111] = 4'd5;
        r_alu[6'b101010] = 4'd6;  r_alu[6'b000000] = 4'd7;  r_alu[6'b000010] = 4'd8;
        r_alu[6'b000011] = 4'd9;
        i_alu[6'b001000] = 4'd0;  i_alu[6'b001010] = 4'd6;  i_alu[6'b001100] = 4'd2;
        i_alu[6'b001101] = 4'd3;  i_alu[6'b001110] = 4'd4;  i_alu[6'b001111] = 4'd10;
        op_list = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000,
                    6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b100011,
                    6'b101011};
        fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b000000, 6'b000010, 6'b000011, 6'b001000};

        rst_n = 1'b0;
        opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;

        next_slot(); apply("reset_nop", 6'b000000, 6'b100000, 1'b0);
        next_slot(); rst_n = 1'b1; apply("release_before_edge", 6'b000000, 6'b100000, 1'b0);
        next_slot(); apply("first_run_add", 6'b000000, 6'b100000, 1'b0);
        next_slot(); apply("radd_zero1", 6'b000000, 6'b100000, 1'b1);
        next_slot(); apply("jal", 6'b000011, 6'b000000, 1'b0);
        next_slot(); apply("beq_z0", 6'b000100, 6'b000000, 1'b0);
        next_slot(); apply("beq_z1", 6'b000100, 6'b000000, 1'b1);
        next_slot(); apply("bne_z0", 6'b000101, 6'b000000, 1'b0);
        next_slot(); apply("bne_z1", 6'b000101, 6'b000000, 1'b1);
        next_slot(); apply("lw", 6'b100011, 6'b000000, 1'b0);
        next_slot(); apply("sw", 6'b101011, 6'b000000, 1'b1);
        next_slot(); apply("bad_opcode", 6'b111111, 6'b100000, 1'b0);
        next_slot(); apply("bad_funct", 6'b000000, 6'b111111, 1'b0);
        next_slot(); apply("jr", 6'b000000, 6'b001000, 1'b0);

        // Zero toggling mid-cycle must reach next_pc_sel without a clock edge
        next_slot();
        opcode = 6'b000100; funct = 6'b000000; zero = 1'b0;
        #1 compare("beq_live_z0", actual_v(), model(1'b1, 6'b000100, 6'b000000, 1'b0));
        zero = 1'b1;
        #1 compare("beq_live_z1", actual_v(), model(1'b1, 6'b000100, 6'b000000, 1'b1));

        // Asynchronous reset mid-instruction forces NOP at once
        @(negedge clk);
        opcode = 6'b100011; #1;
        compare("lw_before_reset", actual_v(), model(1'b1, 6'b100011, 6'b000000, 1'b1));
        rst_n = 1'b0;
        #1 compare("async_reset_nop", actual_v(), NOP_V);
        next_slot(); rst_n = 1'b1; apply("rerelease_nop", 6'b100011, 6'b000000, 1'b0);

        for (int k = 0; k < 400; k++) begin
            int oi, fi;
            logic [5:0] op, fn;
            oi = $urandom_range(0, 15);
            fi = $urandom_range(0, 13);
            op = (oi < 13) ? op_list[oi] : 6'($urandom);
            fn = (fi < 11) ? fn_list[fi] : 6'($urandom);
            next_slot();
            apply("random", op, fn, 1'($urandom));
        end

        repeat (2) @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
